pipe_event_counter: RTL and testbench
=====================================

# pipe_event_counter

Hardware event monitor that sits beside the pipelined CPU core and consumes the stall, flush and retire signals the core produces. It gates counting on `start_i`, runs for a fixed cycle budget, and exposes cycle/stall/flush/retire counts via a snapshot-and-select read port. The simulation harness and the on-chip debug path both use it as the single source of truth for stall and flush statistics.

## Interface
- `CNT_W`, 32: width of every counter and of `rdata_o`
- `MAX_CYCLES`, 64: run-cycle budget; reaching it ends the run
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  asynchronous, active-low reset
- `start_i`  in  1  level; run may begin while high
- `stall_i`  in  1  hazard-detection stall request from ID
- `branch_i`  in  1  taken branch in ID (causes IF/ID flush)
- `retire_i`  in  1  MEM/WB stage holds a valid instruction with RegWrite or a store
- `clear_i`  in  1  synchronous clear of live counters, returns FSM to IDLE
- `snap_i`  in  1  copy live counters into shadow registers
- `sel_i`  in  2  read select: 0 cycle, 1 stall, 2 flush, 3 retire (shadow copies)
- `rdata_o`  out  CNT_W  selected shadow counter, registered
- `running_o`  out  1  FSM in RUN
- `done_o`  out  1  FSM in DONE

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE → RUN when `start_i`=1; counting does not occur in the transition cycle.
- RUN → DONE when live cycle counter equals `MAX_CYCLES`-1 and is incremented (i.e. after exactly `MAX_CYCLES` counted cycles).
- RUN → IDLE if `start_i` drops; live counters hold their values.
- DONE is sticky; only `clear_i` or reset leaves it (to IDLE).
- In RUN, each cycle: cycle += 1; stall += 1 iff `stall_i` & ~`branch_i`; flush += 1 iff `branch_i`; retire += 1 iff `retire_i`.
- A stall coinciding with a branch counts only as a flush.
- All counters saturate at 2^CNT_W−1; no wrap.
- `clear_i` has priority over counting and `start_i`; zeroes live counters, FSM → IDLE. Shadow registers are not cleared by `clear_i`.
- `snap_i` captures live counter values as they stood before this cycle's increment. `snap_i` with `clear_i` captures pre-clear values.
- `rdata_o` reflects `sel_i` and shadow contents from the previous edge (one-cycle read latency).

## Timing
- Reset values: all live and shadow counters 0, `rdata_o`=0, `running_o`=0, `done_o`=0, FSM IDLE.
- Reset asserted mid-run: immediate (asynchronous) return to reset values; no partial counts survive.
- `running_o`/`done_o` are registered state decodes, valid the cycle after the transition edge.
- Event inputs are sampled on the same edge that increments; no input registering.
- Snapshot → `rdata_o` latency: snap at edge N, shadow valid after N, `rdata_o` shows it after edge N+1.
- Input assumption: `stall_i`, `branch_i`, `retire_i` are synchronous to `clk_i` and glitch-free at the edge.

## Structure
- Shared package `pipe_event_pkg`: FSM state enum (IDLE/RUN/DONE), `sel_i` encodings (SEL_CYCLE, SEL_STALL, SEL_FLUSH, SEL_RETIRE).
- One sub-module `sat_counter` (params `W`; ports clk_i, rst_i, clr_i, inc_i, q_o), instantiated four times.
- Top holds the FSM, shadow bank and read mux.

## Test plan
- Reset then `start_i`=1 with no events for 70 cycles → `done_o`=1 after 64 counted cycles; snap reads cycle=64, stall=0, flush=0, retire=0.
- 10 cycles `stall_i`=1, then 3 cycles `stall_i`=`branch_i`=1 → stall=10, flush=3.
- `retire_i` every other cycle for 20 RUN cycles, `snap_i` on cycle 20, `sel_i`=3 → `rdata_o`=10 one cycle after snapshot is valid.
- `start_i` dropped at cycle 30 for 5 cycles then raised → cycle counter holds 30, resumes; `done_o` asserts after 64 total counted cycles.
- `CNT_W`=4, stall held 20 cycles → stall saturates at 15, no wrap.
- `rst_i` pulsed low mid-run between edges → all outputs 0 immediately; `clear_i`+`snap_i` same cycle → shadow keeps pre-clear values, live counters 0, FSM IDLE.

Source files
------------

// File: rtl/pipe_event_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_event_pkg                                                   |
// | Shared state and read-select encodings for pipe_event_counter.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pipe_event_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SEL_CYCLE  = 2'd0;
    localparam logic [1:0] SEL_STALL  = 2'd1;
    localparam logic [1:0] SEL_FLUSH  = 2'd2;
    localparam logic [1:0] SEL_RETIRE = 2'd3;

    localparam int c_num_cnt = 4;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter                                                      |
// | Up-counter with synchronous clear that sticks at all-ones.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_o <= '0;
        end else if (clr_i) begin
            q_o <= '0;
        end else if (inc_i && (q_o != '1)) begin
            q_o <= q_o + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_event_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_event_counter                                               |
// | Cycle/stall/flush/retire monitor with snapshot bank and read mux.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pipe_event_counter
    import pipe_event_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             retire_i,
    input  logic             clear_i,
    input  logic             snap_i,
    input  logic [1:0]       sel_i,
    output logic [CNT_W-1:0] rdata_o,
    output logic             running_o,
    output logic             done_o
);

    // A budget wider than the counter can never be reached; the run then never ends.
    localparam bit c_budget_fits =
        (longint'(MAX_CYCLES) - 1) < (longint'(1) << CNT_W);
    localparam logic [CNT_W-1:0] c_last_cycle = CNT_W'(MAX_CYCLES - 1);

    state_t           r_state;
    logic             r_running;
    logic             r_done;
    logic [CNT_W-1:0] r_rdata;
    logic [CNT_W-1:0] r_shadow [c_num_cnt];
    logic [CNT_W-1:0] w_live   [c_num_cnt];
    logic [c_num_cnt-1:0] w_inc;
    logic             w_count;
    logic             w_last;

    assign w_count = (r_state == RUN) && start_i && !clear_i;
    assign w_last  = c_budget_fits && (w_live[SEL_CYCLE] == c_last_cycle);

    assign w_inc[SEL_CYCLE]  = w_count;
    assign w_inc[SEL_STALL]  = w_count && stall_i && !branch_i;
    assign w_inc[SEL_FLUSH]  = w_count && branch_i;
    assign w_inc[SEL_RETIRE] = w_count && retire_i;

    generate
        for (genvar g = 0; g < c_num_cnt; g++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .clr_i (clear_i),
                .inc_i (w_inc[g]),
                .q_o   (w_live[g])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else if (clear_i) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!start_i) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end else if (w_last) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // Shadows take the live values before this edge's increment or clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < c_num_cnt; i++) r_shadow[i] <= '0;
            r_rdata <= '0;
        end else begin
            if (snap_i) begin
                for (int i = 0; i < c_num_cnt; i++) r_shadow[i] <= w_live[i];
            end
            r_rdata <= r_shadow[sel_i];
        end
    end

    assign rdata_o   = r_rdata;
    assign running_o = r_running;
    assign done_o    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pipe_event_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipe_event_counter                                            |
// | Directed table and sequence checks for pipe_event_counter.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pipe_event_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stall, branch, retire, clear, snap;
    logic [1:0]  sel;
    logic [31:0] rdata;
    logic        running, done_s;
    logic [3:0]  rdata_b;
    logic        running_b, done_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic start, stall, branch, retire, clear, snap;
        logic exp_running, exp_done;
    } vec_t;
    vec_t vecs [10];

    always #5 clk = ~clk;

    pipe_event_counter #(.CNT_W(32), .MAX_CYCLES(64)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall),
        .branch_i(branch), .retire_i(retire), .clear_i(clear), .snap_i(snap),
        .sel_i(sel), .rdata_o(rdata), .running_o(running), .done_o(done_s)
    );

    pipe_event_counter #(.CNT_W(4), .MAX_CYCLES(64)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall),
        .branch_i(branch), .retire_i(retire), .clear_i(clear), .snap_i(snap),
        .sel_i(sel), .rdata_o(rdata_b), .running_o(running_b), .done_o(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic read_shadow(input logic [1:0] s, input logic [31:0] exp, input string name);
        sel = s;
        tick();
        check(name, rdata, exp);
    endtask

    task automatic clear_live();
        start = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running testbench expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1, 0, 0, 0, 0, 0, 1, 0};
        vecs[1] = '{1, 1, 0, 0, 0, 0, 1, 0};
        vecs[2] = '{1, 1, 1, 0, 0, 0, 1, 0};
        vecs[3] = '{1, 0, 0, 1, 0, 0, 1, 0};
        vecs[4] = '{0, 1, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{1, 0, 0, 0, 0, 0, 1, 0};
        vecs[7] = '{1, 1, 0, 1, 0, 0, 1, 0};
        vecs[8] = '{1, 0, 0, 0, 1, 1, 0, 0};
        vecs[9] = '{1, 0, 0, 0, 0, 0, 1, 0};

        rst_n = 1'b0;
        {start, stall, branch, retire, clear, snap} = '0;
        sel = 2'd0;
        #12;
        check("reset rdata", rdata, 0);
        check("reset running", {31'b0, running}, 0);
        check("reset done", {31'b0, done_s}, 0);
        rst_n = 1'b1;

        // Full budget with no events
        start = 1'b1;
        tick();
        check("run entry running", {31'b0, running}, 1);
        repeat (63) tick();
        check("done before budget", {31'b0, done_s}, 0);
        tick();
        check("done at budget", {31'b0, done_s}, 1);
        check("running after done", {31'b0, running}, 0);
        repeat (5) tick();
        check("done sticky", {31'b0, done_s}, 1);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_shadow(2'd0, 64, "budget cycle");
        read_shadow(2'd1, 0, "budget stall");
        read_shadow(2'd2, 0, "budget flush");
        read_shadow(2'd3, 0, "budget retire");
        clear_live();
        check("clear leaves done", {31'b0, done_s}, 0);

        // Table: FSM outputs per cycle, ends with clear+snap
        for (int i = 0; i < 10; i++) begin
            start  = vecs[i].start;
            stall  = vecs[i].stall;
            branch = vecs[i].branch;
            retire = vecs[i].retire;
            clear  = vecs[i].clear;
            snap   = vecs[i].snap;
            tick();
            check($sformatf("vec%0d running", i), {31'b0, running}, {31'b0, vecs[i].exp_running});
            check($sformatf("vec%0d done", i), {31'b0, done_s}, {31'b0, vecs[i].exp_done});
        end
        {start, stall, branch, retire, clear, snap} = '0;
        read_shadow(2'd0, 4, "preclear cycle");
        read_shadow(2'd1, 2, "preclear stall");
        read_shadow(2'd2, 1, "preclear flush");
        read_shadow(2'd3, 2, "preclear retire");
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_shadow(2'd0, 0, "postclear live cycle");

        // Stall versus stall+branch
        clear_live();
        start = 1'b1;
        tick();
        stall = 1'b1;
        repeat (10) tick();
        branch = 1'b1;
        repeat (3) tick();
        {stall, branch, start} = '0;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_shadow(2'd0, 13, "stall seq cycle");
        read_shadow(2'd1, 10, "stall seq stall");
        read_shadow(2'd2, 3, "stall seq flush");
        read_shadow(2'd3, 0, "stall seq retire");

        // Alternate retires, read latency
        clear_live();
        start = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            retire = (i % 2 == 0);
            tick();
        end
        retire = 1'b0;
        snap = 1'b1;
        sel = 2'd3;
        tick();
        check("rdata before latency", rdata, 0);
        snap = 1'b0;
        tick();
        check("retire after latency", rdata, 10);
        read_shadow(2'd0, 20, "retire seq cycle");

        // Start dropped at 30 counted cycles, then resumed
        clear_live();
        start = 1'b1;
        tick();
        repeat (30) tick();
        start = 1'b0;
        repeat (5) tick();
        check("paused running", {31'b0, running}, 0);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_shadow(2'd0, 30, "paused cycle");
        start = 1'b1;
        tick();
        check("resume running", {31'b0, running}, 1);
        repeat (33) tick();
        check("resume done early", {31'b0, done_s}, 0);
        tick();
        check("resume done", {31'b0, done_s}, 1);
        start = 1'b0;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_shadow(2'd0, 64, "resume cycle");

        // Saturation on the 4-bit instance
        clear_live();
        start = 1'b1;
        tick();
        stall = 1'b1;
        repeat (20) tick();
        {stall, start} = '0;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_shadow(2'd1, 20, "wide stall");
        check("narrow stall sat", {28'b0, rdata_b}, 15);
        sel = 2'd0;
        tick();
        check("narrow cycle sat", {28'b0, rdata_b}, 15);
        check("narrow never done", {31'b0, done_b}, 0);

        // Asynchronous reset between edges
        clear_live();
        start = 1'b1;
        tick();
        retire = 1'b1;
        repeat (5) tick();
        retire = 1'b0;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        sel = 2'd3;
        tick();
        check("prereset rdata", rdata, 5);
        check("prereset running", {31'b0, running}, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rdata", rdata, 0);
        check("async running", {31'b0, running}, 0);
        check("async done", {31'b0, done_s}, 0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("async shadow", rdata, 0);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        read_shadow(2'd3, 0, "async live retire");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
